stream_demux1x2: RTL and testbench

//   Sequential 1-to-2 packet demultiplexer: the receive-side counterpart of the 2:1 mux.

---
 rtl/stream_demux_pkg.sv | 21 ++
 rtl/stream_demux1x2_slot.sv | 74 +++++++
 rtl/stream_demux1x2.sv | 169 ++++++++++++++++
 tb/tb_stream_demux1x2.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared types and default sizes for the 1-to-2 stream demultiplexer.
//   state_t              : packet-routing FSM states
//   DEFAULT_WIDTH        : default data bits per beat
//   DEFAULT_COUNT_WIDTH  : default width of the optional per-output packet counters
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  // IDLE waits for the first beat of a packet; ROUTE0/ROUTE1 mean a packet is
  // in flight and its destination is locked until the beat carrying last.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_COUNT_WIDTH = 16;

endpackage : stream_demux_pkg

// File: rtl/stream_demux1x2_slot.sv
// -----------------------------------------------------------------------------
// stream_out_slot
// One-entry valid/ready output register carrying data plus an end-of-packet
// flag. The demux owns one of these per output.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : capture data_i/last_i this cycle (caller guarantees can_load_o)
//   data_i       : beat data to capture
//   last_i       : end-of-packet flag to capture
//   ready_i      : downstream consumer ready
//   valid_o      : slot holds a beat
//   data_o       : held beat data (stable while stalled)
//   last_o       : held end-of-packet flag (stable while stalled)
//   can_load_o   : slot is empty or is being drained this cycle
// -----------------------------------------------------------------------------
module stream_out_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic             can_load_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             last_q,  last_d;

  // A load wins over a drain in the same cycle, which is what gives the
  // output full one-beat-per-cycle throughput. Data and last only change on
  // a load, so they stay frozen while the consumer stalls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Reset empties the slot and zeroes the held beat so nothing stale is
  // presented after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Room for a new beat exists when empty or when the held beat leaves now.
  assign can_load_o = !valid_q || ready_i;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule : stream_out_slot

// File: rtl/stream_demux1x2.sv
// -----------------------------------------------------------------------------
// stream_demux1x2
// Sequential 1-to-2 packet demultiplexer. The destination is taken from
// in_sel on the first beat of each packet and held until the beat with
// in_last. Each output is a one-entry register, so an accepted beat shows up
// on its output one cycle later.
// Optional feature macro: STREAM_DEMUX_COUNT_EN adds out0_count/out1_count,
// per-output counters of completed (consumed last-beat) packets, wrapping
// modulo 2**COUNT_WIDTH.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : input handshake
//   in_data, in_last         : input beat payload and end-of-packet
//   in_sel                   : destination, sampled on a packet's first beat
//   outN_valid/outN_ready    : output N handshake
//   outN_data, outN_last     : output N payload and end-of-packet
//   outN_count               : completed packets on output N (macro only)
// -----------------------------------------------------------------------------
module stream_demux1x2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_last,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_last,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_last
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out0_count,
  output logic [COUNT_WIDTH-1:0] out1_count
`endif
);

  // Elaboration-time sanity check on the sizing parameters.
  if (WIDTH < 1 || COUNT_WIDTH < 1) begin : g_param_check
    $error("stream_demux1x2: WIDTH and COUNT_WIDTH must be at least 1");
  end

  state_t state_q, state_d;
  logic   dest;
  logic   accept;
  logic   load0, load1;
  logic   can_load0, can_load1;

  // The destination follows in_sel only while idle; mid-packet it is the
  // locked route, so toggling in_sel inside a packet has no effect.
  always_comb begin
    dest = 1'b0;
    unique case (state_q)
      IDLE:    dest = in_sel;
      ROUTE0:  dest = 1'b0;
      ROUTE1:  dest = 1'b1;
      default: dest = 1'b0;
    endcase
  end

  // in_ready looks only at the chosen slot, so a stalled output never holds
  // up a packet heading for the other one. in_valid is deliberately kept out
  // of this path.
  assign in_ready = dest ? can_load1 : can_load0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !dest;
  assign load1    = accept &&  dest;

  // Next-state logic: a multi-beat packet locks its route on the first beat,
  // single-beat packets never leave IDLE, and the beat carrying last always
  // returns to IDLE. Without accepted beats the state simply holds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = in_sel ? ROUTE1 : ROUTE0;
        end
      end
      ROUTE0, ROUTE1: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any packet in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  stream_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load0),
    .data_i     (in_data),
    .last_i     (in_last),
    .ready_i    (out0_ready),
    .valid_o    (out0_valid),
    .data_o     (out0_data),
    .last_o     (out0_last),
    .can_load_o (can_load0)
  );

  stream_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load1),
    .data_i     (in_data),
    .last_i     (in_last),
    .ready_i    (out1_ready),
    .valid_o    (out1_valid),
    .data_o     (out1_data),
    .last_o     (out1_last),
    .can_load_o (can_load1)
  );

`ifdef STREAM_DEMUX_COUNT_EN
  logic [COUNT_WIDTH-1:0] count0_q, count0_d;
  logic [COUNT_WIDTH-1:0] count1_q, count1_d;

  // A packet counts as complete when its last beat is actually consumed
  // downstream, not when it enters the demux. Plain addition wraps.
  always_comb begin
    count0_d = count0_q;
    count1_d = count1_q;
    if (out0_valid && out0_ready && out0_last) begin
      count0_d = count0_q + 1'b1;
    end
    if (out1_valid && out1_ready && out1_last) begin
      count1_d = count1_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign out0_count = count0_q;
  assign out1_count = count1_q;
`endif

endmodule : stream_demux1x2

// File: tb/tb_stream_demux1x2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux1x2
// Self-checking bench for stream_demux1x2: directed scenarios followed by a
// randomized run compared against a packet-level reference model.
// Counter checks are compiled in when STREAM_DEMUX_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_demux1x2;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_last;
  logic          out0_valid, out0_ready, out0_last;
  logic [W-1:0]  out0_data;
  logic          out1_valid, out1_ready, out1_last;
  logic [W-1:0]  out1_data;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [CW-1:0] out0_count, out1_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  stream_demux1x2 #(
    .WIDTH       (W),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  // 10 ns clock; stimulus changes on the falling edge, checks follow 1 ns later.
  always #5 clk = ~clk;

  // Drive every DUT input for the coming rising edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic s,
                               input logic l, input logic r0, input logic r1);
    in_valid   = v;
    in_data    = d;
    in_sel     = s;
    in_last    = l;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Hold reset over a few edges, releasing it on a falling edge.
  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out0_valid: got %b want 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out1_valid: got %b want 0", out1_valid); end
    checks++; if (out0_data !== 8'h00 || out0_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out0_payload: got %h/%b want 00/0", out0_data, out0_last); end
    checks++; if (out1_data !== 8'h00 || out1_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out1_payload: got %h/%b want 00/0", out1_data, out1_last); end
`ifdef STREAM_DEMUX_COUNT_EN
    checks++; if (out0_count !== 2'd0 || out1_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", out0_count, out1_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Two single-beat packets, both consumers always ready.
  task automatic test_single_beat();
    @(negedge clk);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready0: got %b want 1", in_ready); end
    @(negedge clk);
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready1: got %b want 1", in_ready); end
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA5 || out0_last !== 1'b1) begin errors++; $display("[TB] FAIL single_out0: got v=%b d=%h l=%b want v=1 d=a5 l=1", out0_valid, out0_data, out0_last); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_out1_idle: got %b want 0", out1_valid); end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h3C || out1_last !== 1'b1) begin errors++; $display("[TB] FAIL single_out1: got v=%b d=%h l=%b want v=1 d=3c l=1", out1_valid, out1_data, out1_last); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_out0_drained: got %b want 0", out0_valid); end
    @(negedge clk);
  endtask

  // Four-beat packet to out1 with in_sel toggling after the first beat.
  task automatic test_sticky_route();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) applyStimulus(1'b1, 8'(i + 1), (i == 0) ? 1'b1 : ((i % 2) == 0), (i == 3), 1'b1, 1'b1);
      else       applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      if (i < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sticky_ready beat%0d: got %b want 1", i + 1, in_ready); end
      end
      if (i > 0) begin
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'(i) || out1_last !== (i == 4)) begin errors++; $display("[TB] FAIL sticky_out1 beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out1_valid, out1_data, out1_last, 8'(i), (i == 4)); end
      end
      checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL sticky_out0_quiet step%0d: got %b want 0", i, out0_valid); end
    end
    @(negedge clk);
  endtask

  // Full, stalled out0 blocks a second out0 beat until out0_ready returns.
  task automatic test_backpressure();
    @(negedge clk);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b want 0", in_ready); end
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin errors++; $display("[TB] FAIL bp_hold1: got v=%b d=%h want v=1 d=55", out0_valid, out0_data); end
    @(negedge clk);
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h55 || out0_last !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold2: got v=%b d=%h l=%b want v=1 d=55 l=1", out0_valid, out0_data, out0_last); end
    out0_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_drain: got %b want 1", in_ready); end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h66) begin errors++; $display("[TB] FAIL bp_reload: got v=%b d=%h want v=1 d=66", out0_valid, out0_data); end
    @(negedge clk);
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %b want 0", out0_valid); end
  endtask

  // A stalled out0 does not hold up a packet for out1.
  task automatic test_independence();
    @(negedge clk);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL indep_ready: got %b want 1", in_ready); end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h22) begin errors++; $display("[TB] FAIL indep_out1: got v=%b d=%h want v=1 d=22", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h11) begin errors++; $display("[TB] FAIL indep_out0_held: got v=%b d=%h want v=1 d=11", out0_valid, out0_data); end
    out0_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("[TB] FAIL indep_empty: got v0=%b v1=%b want 0/0", out0_valid, out1_valid); end
  endtask

  // Reset after beat 2 of a four-beat out0 packet, then a fresh out1 packet.
  task automatic test_reset_mid_packet();
    @(negedge clk);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h02) begin errors++; $display("[TB] FAIL rstmid_pre: got v=%b d=%h want v=1 d=02", out0_valid, out0_data); end
    rst = 1'b1;
    #1;
    checks++; if (out0_valid !== 1'b0 || out0_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_async: got v=%b d=%h want v=0 d=00", out0_valid, out0_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin errors++; $display("[TB] FAIL rstmid_route: got v=%b d=%h want v=1 d=77", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out0: got %b want 0", out0_valid); end
    @(negedge clk);
  endtask

`ifdef STREAM_DEMUX_COUNT_EN
  // Five single-beat packets to out1 with a 2-bit counter: 1,2,3,0,1.
  task automatic test_count();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checks++; if (out1_count !== 2'((i + 1) % 4)) begin errors++; $display("[TB] FAIL count_out1 pkt%0d: got %0d want %0d", i + 1, out1_count, (i + 1) % 4); end
      checks++; if (out0_count !== 2'd0) begin errors++; $display("[TB] FAIL count_out0 pkt%0d: got %0d want 0", i + 1, out0_count); end
    end
  endtask
`endif

  // Random packets, gaps and backpressure against a per-output beat queue.
  task automatic test_random();
    beat_t        q0[$];
    beat_t        q1[$];
    logic         pending = 1'b0;
    logic         pkt_dest = 1'b0;
    int           pkt_len = 1;
    int           beat_idx = 0;
    logic [W-1:0] beat_data = '0;
    logic         v, s, l, r0, r1, exp_ready;
    beat_t        head;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (!pending) begin
        pkt_dest  = 1'($urandom);
        pkt_len   = $urandom_range(1, 4);
        beat_idx  = 0;
        beat_data = 8'($urandom);
        pending   = 1'b1;
      end
      v  = ($urandom % 4) != 0;
      r0 = ($urandom % 3) != 0;
      r1 = ($urandom % 3) != 0;
      s  = (beat_idx == 0) ? pkt_dest : 1'($urandom);
      l  = (beat_idx == pkt_len - 1);
      applyStimulus(v, beat_data, s, l, r0, r1);
      #1;
      exp_ready = pkt_dest ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ready); end
      checks++; if (out0_valid !== (q0.size() > 0)) begin errors++; $display("[TB] FAIL rand_out0_valid cyc%0d: got %b want %b", cyc, out0_valid, (q0.size() > 0)); end
      checks++; if (out1_valid !== (q1.size() > 0)) begin errors++; $display("[TB] FAIL rand_out1_valid cyc%0d: got %b want %b", cyc, out1_valid, (q1.size() > 0)); end
      if (q0.size() > 0) begin
        head = q0[0];
        checks++; if (out0_data !== head.data || out0_last !== head.last) begin errors++; $display("[TB] FAIL rand_out0_beat cyc%0d: got %h/%b want %h/%b", cyc, out0_data, out0_last, head.data, head.last); end
      end
      if (q1.size() > 0) begin
        head = q1[0];
        checks++; if (out1_data !== head.data || out1_last !== head.last) begin errors++; $display("[TB] FAIL rand_out1_beat cyc%0d: got %h/%b want %h/%b", cyc, out1_data, out1_last, head.data, head.last); end
      end
      if (q0.size() > 0 && r0) void'(q0.pop_front());
      if (q1.size() > 0 && r1) void'(q1.pop_front());
      if (v && exp_ready) begin
        if (pkt_dest) q1.push_back('{last: l, data: beat_data});
        else          q0.push_back('{last: l, data: beat_data});
        if (l) begin
          pending = 1'b0;
        end else begin
          beat_idx++;
          beat_data = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_sticky_route();
    test_backpressure();
    test_independence();
    test_reset_mid_packet();
`ifdef STREAM_DEMUX_COUNT_EN
    test_count();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_demux1x2
